// File: rtl/doc_hw_cmd_seq_if.sv
// Avalon-ST command channel between the DOC command sequencer and the mailbox.
// The sequencer is the master; the mailbox (or a bench) is the slave.
interface doc_hw_cmd_seq_if;
    logic        command_valid_o;
    logic        command_ready_i;
    logic [31:0] command_data_o;
    logic        command_startofpacket_o;
    logic        command_endofpacket_o;

    modport master (
        output command_valid_o,
        output command_data_o,
        output command_startofpacket_o,
        output command_endofpacket_o,
        input  command_ready_i
    );

    modport slave (
        input  command_valid_o,
        input  command_data_o,
        input  command_startofpacket_o,
        input  command_endofpacket_o,
        output command_ready_i
    );
endinterface

// File: rtl/doc_hw_cmd_seq.sv
// DOC monitor command sequencer: sweeps voltage then temperature channels,
// one two-word mailbox packet per channel, pacing on the checker's is_good.
module doc_hw_cmd_seq #(
    parameter int P_NO_CHANNELS      = 9,
    parameter int P_NO_TEMP_CHANNELS = 4,
    parameter int P_SCAN_PERIOD      = 1000,
    parameter int P_RSP_TIMEOUT      = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    doc_hw_cmd_seq_if.master         cmd,
    input  logic                     is_good,
    output logic                     is_volt,
    output logic                     is_temp,
    output logic [P_NO_CHANNELS-1:0] current_voltage_channel,
    output logic [3:0]               current_temperature_channel,
    output logic                     busy,
    output logic                     scan_done,
    output logic                     timeout_err,
    output logic [7:0]               timeout_count
);
    localparam int RSP_W = $clog2(P_RSP_TIMEOUT);
    localparam int PER_W = $clog2(P_SCAN_PERIOD + 1);
    localparam logic [RSP_W-1:0]         RSP_LAST  = RSP_W'(P_RSP_TIMEOUT - 1);
    localparam logic [PER_W-1:0]         PER_LAST  = PER_W'(P_SCAN_PERIOD - 1);
    localparam logic [3:0]               TCH_LAST  = 4'(P_NO_TEMP_CHANNELS - 1);
    localparam logic [P_NO_CHANNELS-1:0] VCH_FIRST = P_NO_CHANNELS'(1);

    typedef enum logic [2:0] {
        IDLE, SEND_HDR, SEND_ARG, WAIT_RSP, NEXT, WAIT_PERIOD
    } state_t;

    state_t                   state_reg, state_next;
    logic [3:0]               id_reg, id_next;
    logic [RSP_W-1:0]         rsp_cnt_reg, rsp_cnt_next;
    logic [PER_W-1:0]         per_cnt_reg, per_cnt_next;
    logic                     is_volt_reg, is_volt_next;
    logic                     is_temp_reg, is_temp_next;
    logic [P_NO_CHANNELS-1:0] vch_reg, vch_next;
    logic [3:0]               tch_reg, tch_next;
    logic                     terr_reg, terr_next;
    logic [7:0]               tcnt_reg, tcnt_next;
    logic                     scan_done_c;

    logic [31:0] volt_arg;
    logic [31:0] hdr_word;
    logic [31:0] arg_word;
    logic [10:0] cmd_code;

    // Voltage argument is the one-hot select itself, zero-padded to 32 bits.
    for (genvar gi = 0; gi < 32; gi++) begin : g_arg
        if (gi < P_NO_CHANNELS) begin : g_ch
            assign volt_arg[gi] = vch_reg[gi];
        end else begin : g_pad
            assign volt_arg[gi] = 1'b0;
        end
    end

    assign cmd_code = is_volt_reg ? 11'h018 : 11'h019;
    assign hdr_word = {4'h0, id_reg, 1'b0, 11'd1, 1'b0, cmd_code};
    assign arg_word = is_volt_reg ? volt_arg : {28'h0, tch_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            rsp_cnt_reg <= '0;
            per_cnt_reg <= '0;
            is_volt_reg <= 1'b0;
            is_temp_reg <= 1'b0;
            vch_reg     <= '0;
            tch_reg     <= '0;
            terr_reg    <= 1'b0;
            tcnt_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            rsp_cnt_reg <= rsp_cnt_next;
            per_cnt_reg <= per_cnt_next;
            is_volt_reg <= is_volt_next;
            is_temp_reg <= is_temp_next;
            vch_reg     <= vch_next;
            tch_reg     <= tch_next;
            terr_reg    <= terr_next;
            tcnt_reg    <= tcnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        id_next      = id_reg;
        rsp_cnt_next = rsp_cnt_reg;
        per_cnt_next = per_cnt_reg;
        is_volt_next = is_volt_reg;
        is_temp_next = is_temp_reg;
        vch_next     = vch_reg;
        tch_next     = tch_reg;
        terr_next    = terr_reg;
        tcnt_next    = tcnt_reg;
        scan_done_c  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next   = SEND_HDR;
                    is_volt_next = 1'b1;
                    is_temp_next = 1'b0;
                    vch_next     = VCH_FIRST;
                    tch_next     = '0;
                end
            end
            SEND_HDR: begin
                if (cmd.command_ready_i) state_next = SEND_ARG;
            end
            SEND_ARG: begin
                if (cmd.command_ready_i) begin
                    state_next   = WAIT_RSP;
                    rsp_cnt_next = '0;
                    id_next      = id_reg + 4'd1;
                end
            end
            WAIT_RSP: begin
                // is_good wins over an expiring timer in the same cycle.
                if (is_good) begin
                    state_next = NEXT;
                end else if (rsp_cnt_reg == RSP_LAST) begin
                    state_next = NEXT;
                    terr_next  = 1'b1;
                    if (tcnt_reg != 8'hFF) tcnt_next = tcnt_reg + 8'd1;
                end else begin
                    rsp_cnt_next = rsp_cnt_reg + 1'b1;
                end
            end
            NEXT: begin
                if (!is_volt_reg && tch_reg == TCH_LAST) begin
                    scan_done_c  = 1'b1;
                    state_next   = enable ? WAIT_PERIOD : IDLE;
                    per_cnt_next = '0;
                    is_temp_next = 1'b0;
                    tch_next     = '0;
                end else if (!enable) begin
                    state_next   = IDLE;
                    is_volt_next = 1'b0;
                    is_temp_next = 1'b0;
                    vch_next     = '0;
                    tch_next     = '0;
                end else begin
                    state_next = SEND_HDR;
                    if (is_volt_reg && vch_reg[P_NO_CHANNELS-1]) begin
                        is_volt_next = 1'b0;
                        is_temp_next = 1'b1;
                        vch_next     = '0;
                        tch_next     = '0;
                    end else if (is_volt_reg) begin
                        vch_next = vch_reg << 1;
                    end else begin
                        tch_next = tch_reg + 4'd1;
                    end
                end
            end
            WAIT_PERIOD: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (per_cnt_reg == PER_LAST) begin
                    state_next   = SEND_HDR;
                    is_volt_next = 1'b1;
                    vch_next     = VCH_FIRST;
                end else begin
                    per_cnt_next = per_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command outputs decode straight from registered state, so reset kills valid at once.
    assign cmd.command_valid_o         = (state_reg == SEND_HDR) || (state_reg == SEND_ARG);
    assign cmd.command_startofpacket_o = (state_reg == SEND_HDR);
    assign cmd.command_endofpacket_o   = (state_reg == SEND_ARG);
    assign cmd.command_data_o          = (state_reg == SEND_HDR) ? hdr_word :
                                         (state_reg == SEND_ARG) ? arg_word : 32'h0;

    assign is_volt                     = is_volt_reg;
    assign is_temp                     = is_temp_reg;
    assign current_voltage_channel     = vch_reg;
    assign current_temperature_channel = tch_reg;
    assign busy                        = (state_reg != IDLE);
    assign scan_done                   = scan_done_c;
    assign timeout_err                 = terr_reg;
    assign timeout_count               = tcnt_reg;
endmodule
